// File: rtl/scan_pkg.sv
// Shared types and helpers for the display-scan counter.
// The optional SCAN_BLANK_EN build macro is consumed by scan_counter.
package scan_pkg;

    typedef enum logic {
        DIR_ARRIBA = 1'b0,
        DIR_ABAJO  = 1'b1
    } dir_t;

    // Loads at or beyond the count range are pinned to the last digit.
    function automatic int unsigned clamp_limit(input int unsigned value, input int unsigned limit);
        int unsigned result;
        if (value >= limit) begin
            result = limit - 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_counter_tick_divider.sv
// Prescaler for the scan counter: emits a tick on every PRESCALE-th enabled cycle.
module tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic habilitar,
    input  logic limpiar,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("tick_divider: PRESCALE must be >= 1");
    end

    // Tick is combinational so the count register advances on the same edge.
    always_comb begin
        tick = habilitar && (cnt_q == LAST);
    end

    // Next prescaler value: clear on load, wrap on tick, freeze when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (limpiar) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (habilitar) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_counter.sv
// Display-scan counter with prescaler, up/down, load, wrap pulse and anode decode.
// Build macro SCAN_BLANK_EN blanks all anodes for the cycle in which avance is high.
module scan_counter
    import scan_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 7,
    parameter int PRESCALE = 1
) (
    input  logic              reloj_actualizacion,
    input  logic              reset,
    input  logic              habilitar,
    input  logic              dir_abajo,
    input  logic              cargar,
    input  logic [WIDTH-1:0]  valor_carga,
    output logic [WIDTH-1:0]  contador_actualizar,
    output logic              avance,
    output logic              fin_cuenta,
    output logic [MODULO-1:0] anodo_n
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             avance_q;
    logic             avance_d;
    logic             fin_q;
    logic             fin_d;
    logic             tick_s;
    dir_t             dir_s;

    if ((MODULO < 2) || (MODULO > (2 ** WIDTH))) begin : g_bad_modulo
        $error("scan_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("scan_counter: PRESCALE must be >= 1");
    end

    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_tick_divider (
        .clk       (reloj_actualizacion),
        .reset     (reset),
        .habilitar (habilitar),
        .limpiar   (cargar),
        .tick      (tick_s)
    );

    // Next count and pulses; a load suppresses any coincident advance.
    always_comb begin
        dir_s    = dir_t'(dir_abajo);
        count_d  = count_q;
        avance_d = 1'b0;
        fin_d    = 1'b0;
        if (cargar) begin
            count_d = WIDTH'(clamp_limit(32'(valor_carga), 32'(MODULO)));
        end else if (tick_s) begin
            avance_d = 1'b1;
            case (dir_s)
                DIR_ARRIBA: begin
                    if (count_q == MAX_CNT) begin
                        count_d = '0;
                        fin_d   = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                DIR_ABAJO: begin
                    if (count_q == '0) begin
                        count_d = MAX_CNT;
                        fin_d   = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // Count and pulse registers.
    always_ff @(posedge reloj_actualizacion) begin
        if (reset) begin
            count_q  <= '0;
            avance_q <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            avance_q <= avance_d;
            fin_q    <= fin_d;
        end
    end

    // Active-low one-hot anode select from the registered count.
    always_comb begin
        anodo_n = '1;
        for (int i = 0; i < MODULO; i++) begin
            if (count_q == WIDTH'(i)) begin
                anodo_n[i] = 1'b0;
            end else begin
                anodo_n[i] = 1'b1;
            end
        end
`ifdef SCAN_BLANK_EN
        if (avance_q) begin
            anodo_n = '1;
        end else begin
            anodo_n = anodo_n;
        end
`endif
    end

    assign contador_actualizar = count_q;
    assign avance              = avance_q;
    assign fin_cuenta          = fin_q;

endmodule
